// File: rtl/iter_divider.sv
// Radix-2 restoring divider: one quotient bit per cycle, returns {quotient, remainder}.
// Define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module iter_divider #(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tvalid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             r_state, w_state_nx;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_quo, r_dvs;
  logic               r_sn, r_sd, r_dz;
  logic [2*WIDTH-1:0] r_dout;

  logic               w_acc, w_early, w_last, w_ge;
  logic               w_dvd_neg, w_dvs_neg;
  logic [WIDTH-1:0]   w_dvd_mag, w_dvs_mag;
  logic [WIDTH+1:0]   w_sh, w_diff;
  logic [WIDTH:0]     w_rem_nx;
  logic [WIDTH-1:0]   w_quo_nx, w_q_fin, w_r_fin;

  assign w_acc     = (r_state == IDLE) && s_axis_divisor_tvalid && s_axis_dividend_tvalid;
  assign w_dvd_neg = (SIGNED != 0) && s_axis_dividend_tdata[WIDTH-1];
  assign w_dvs_neg = (SIGNED != 0) && s_axis_divisor_tdata[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
  assign w_dvs_mag = w_dvs_neg ? -s_axis_divisor_tdata : s_axis_divisor_tdata;

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (w_dvs_mag != '0) && (w_dvd_mag < w_dvs_mag);
`else
  assign w_early = 1'b0;
`endif

  // r_quo starts as |dividend| and shifts out MSB-first while quotient bits shift in.
  assign w_sh     = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_sh - {2'b00, r_dvs};
  assign w_ge     = ~w_diff[WIDTH+1];
  assign w_rem_nx = w_ge ? w_diff[WIDTH:0] : w_sh[WIDTH:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};
  assign w_last   = (r_cnt == LAST);

  // Divide-by-zero leaves |dividend| in the remainder, so the sign fix restores the raw input.
  assign w_q_fin = r_dz ? '1 : ((r_sn ^ r_sd) ? -w_quo_nx : w_quo_nx);
  assign w_r_fin = r_sn ? -w_rem_nx[WIDTH-1:0] : w_rem_nx[WIDTH-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_state_nx = w_early ? DONE : BUSY;
      BUSY:    if (w_last) w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_axis_divisor_tready  = (r_state == IDLE);
    s_axis_dividend_tready = (r_state == IDLE);
    m_axis_dout_tvalid     = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_sn   <= 1'b0;
      r_sd   <= 1'b0;
      r_dz   <= 1'b0;
      r_dout <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_quo <= w_dvd_mag;
          r_dvs <= w_dvs_mag;
          r_rem <= '0;
          r_sn  <= w_dvd_neg;
          r_sd  <= w_dvs_neg;
          r_dz  <= (s_axis_divisor_tdata == '0);
          r_cnt <= '0;
          if (w_early) r_dout <= {{WIDTH{1'b0}}, s_axis_dividend_tdata};
        end
        BUSY: begin
          r_quo <= w_quo_nx;
          r_rem <= w_rem_nx;
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last) r_dout <= {w_q_fin, w_r_fin};
        end
        default: ;
      endcase
    end
  end

  assign m_axis_dout_tdata = r_dout;

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: unsigned and signed instances checked against an arithmetic model.
module tb_iter_divider;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sel = 1'b0;

  logic [31:0] u_dvs = '0, u_dvd = '0, s_dvs = '0, s_dvd = '0;
  logic        u_vs = 1'b0, u_vd = 1'b0, s_vs = 1'b0, s_vd = 1'b0;
  logic        u_rs, u_rd, u_tv, s_rs, s_rd, s_tv;
  logic [63:0] u_td, s_td;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  iter_divider #(.WIDTH(32), .SIGNED(0)) u_dut_u (
    .clk(clk), .resetn(resetn),
    .s_axis_divisor_tdata(u_dvs), .s_axis_divisor_tvalid(u_vs), .s_axis_divisor_tready(u_rs),
    .s_axis_dividend_tdata(u_dvd), .s_axis_dividend_tvalid(u_vd), .s_axis_dividend_tready(u_rd),
    .m_axis_dout_tdata(u_td), .m_axis_dout_tvalid(u_tv)
  );

  iter_divider #(.WIDTH(32), .SIGNED(1)) u_dut_s (
    .clk(clk), .resetn(resetn),
    .s_axis_divisor_tdata(s_dvs), .s_axis_divisor_tvalid(s_vs), .s_axis_divisor_tready(s_rs),
    .s_axis_dividend_tdata(s_dvd), .s_axis_dividend_tvalid(s_vd), .s_axis_dividend_tready(s_rd),
    .m_axis_dout_tdata(s_td), .m_axis_dout_tvalid(s_tv)
  );

  wire        w_tv   = sel ? s_tv : u_tv;
  wire        w_rdy  = sel ? s_rs : u_rs;
  wire        w_rdy2 = sel ? s_rd : u_rd;
  wire [63:0] w_td   = sel ? s_td : u_td;

  function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  function automatic int ref_lat(input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    ma = sg ? longint'($signed(a)) : longint'({32'd0, a});
    mb = sg ? longint'($signed(b)) : longint'({32'd0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    return (EARLY && mb != 0 && ma < mb) ? 1 : 33;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input bit va, input bit vb);
    if (sel) begin s_dvd = a; s_dvs = b; s_vd = va; s_vs = vb; end
    else     begin u_dvd = a; u_dvs = b; u_vd = va; u_vs = vb; end
  endtask

  // pre = cycles with only divisor valid before the real handshake.
  task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b, input int pre,
                        input string tag);
    logic [63:0] exp, got_d;
    int exp_lat, got, pulses, rdy_bad, rdy_after, pre_bad;
    sel = sg;
    exp = ref_div(sg, a, b);
    exp_lat = ref_lat(sg, a, b);
    got = 0; got_d = '0; pulses = 0; rdy_bad = 0; rdy_after = 0; pre_bad = 0;
    @(negedge clk);
    if (pre > 0) begin
      drive(a, b, 1'b0, 1'b1);
      for (int p = 0; p < pre; p++) begin
        if (!w_rdy || !w_rdy2 || w_tv) pre_bad++;
        @(negedge clk);
      end
    end
    drive(a, b, 1'b1, 1'b1);
    if (!w_rdy || !w_rdy2) pre_bad++;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) drive(a, b, 1'b0, 1'b0);
      if (w_tv) begin
        pulses++;
        if (got == 0) begin got = k; got_d = w_td; end
      end
      if (w_rdy !== w_rdy2) rdy_bad++;
      if (k <= exp_lat && w_rdy) rdy_bad++;
      if (k == exp_lat + 1) rdy_after = int'(w_rdy);
    end
    chk({tag, "_lat"},     64'(got), 64'(exp_lat));
    chk({tag, "_data"},    got_d, exp);
    chk({tag, "_pulses"},  64'(pulses), 64'd1);
    chk({tag, "_busyrdy"}, 64'(rdy_bad), 64'd0);
    chk({tag, "_rdyback"}, 64'(rdy_after), 64'd1);
    chk({tag, "_preidle"}, 64'(pre_bad), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    int pulses;
    repeat (3) @(negedge clk);
    chk("rst_u_rdy", {62'd0, u_rs, u_rd}, 64'd3);
    chk("rst_s_rdy", {62'd0, s_rs, s_rd}, 64'd3);
    chk("rst_u_out", {u_td[62:0], u_tv} ^ {u_td[63], 63'd0}, 64'd0);
    chk("rst_s_out", {s_td[62:0], s_tv} ^ {s_td[63], 63'd0}, 64'd0);
    resetn = 1'b1;

    run_op(1'b0, 32'd100, 32'd7, 0, "u100_7");
    chk("u100_7_const", u_td, 64'h0000000E_00000002);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "sm7_2");
    chk("sm7_2_const", s_td, 64'hFFFFFFFD_FFFFFFFF);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "s_ovf");
    chk("s_ovf_const", s_td, 64'h80000000_00000000);
    run_op(1'b0, 32'd5, 32'd0, 0, "u_dz");
    run_op(1'b1, 32'd5, 32'd0, 0, "s_dz");
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 0, "s_dzneg");
    run_op(1'b0, 32'd100, 32'd7, 5, "u_partial");
    run_op(1'b0, 32'd3, 32'd10, 0, "u3_10");
    run_op(1'b1, 32'hFFFF_FFFD, 32'd10, 0, "sm3_10");
    run_op(1'b0, 32'd0, 32'd9, 0, "u0_9");
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, "umax_1");
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "umax_max");
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, "s7_m2");

    // Reset in the middle of an operation must swallow its result.
    sel = 1'b0;
    @(negedge clk);
    drive(32'd100, 32'd7, 1'b1, 1'b1);
    @(negedge clk);
    drive(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("abort_out", {u_td, u_tv, u_rs, u_rd} ^ 67'd3, 67'd0);
    @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (u_tv) pulses++;
    end
    chk("abort_nopulse", 64'(pulses), 64'd0);
    run_op(1'b0, 32'd9, 32'd3, 0, "u9_3");
    chk("u9_3_const", u_td, 64'h00000003_00000000);

    for (int i = 0; i < 24; i++) begin
      for (int s = 0; s < 2; s++) begin
        a = $urandom;
        case ($urandom_range(0, 3))
          0: b = $urandom;
          1: b = $urandom_range(0, 15);
          2: begin b = $urandom; a = $urandom_range(0, 3); end
          default: begin b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h8000_0000; end
        endcase
        run_op(s[0], a, b, $urandom_range(0, 2), s[0] ? "rnd_s" : "rnd_u");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
